// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Parses 5-byte register-write frames received from a UART:
//     0xA5, ADDR, DHI, DLO, CHK   with CHK = ADDR ^ DHI ^ DLO
//   A good frame produces a one-cycle register write and an ACK (0x06)
//   response byte. A bad checksum produces a NAK (0x15) and bumps the
//   error counter. A frame that stalls for TIMEOUT cycles between bytes
//   is dropped silently and also bumps the error counter.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_rx_done_tick    receiver strobe, i_rx_data valid
//   i_rx_data         received byte
//   i_tx_done_tick    transmitter strobe, response byte has been sent
//   o_tx_start        one-cycle transmit request
//   o_tx_data         response byte, held until the next response
//   o_wr_en           one-cycle register-write strobe
//   o_wr_addr         write address, held until the next write
//   o_wr_data         write data, held until the next write
//   o_err_cnt         saturating count of rejected frames
//   o_busy            high whenever a frame is in progress
module uart_cmd_parser #(
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 10_000,
   parameter int TO_BIT    = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rx_done_tick,
   input  logic [DATA_BITS-1:0] i_rx_data,
   input  logic                 i_tx_done_tick,
   output logic                 o_tx_start,
   output logic [DATA_BITS-1:0] o_tx_data,
   output logic                 o_wr_en,
   output logic [7:0]           o_wr_addr,
   output logic [15:0]          o_wr_data,
   output logic [7:0]           o_err_cnt,
   output logic                 o_busy
);

   typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CHK, WAIT_TX} state_t;

   localparam logic [7:0] HDR = 8'hA5;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   state_t            state_q, state_d;
   logic [TO_BIT-1:0] to_cnt;
   logic [7:0]        addr_r, dhi_r, dlo_r;
   logic [7:0]        rx_byte;
   logic              expired;
   logic              lat_addr, lat_dhi, lat_dlo;
   logic              do_wr, do_resp, chk_ok, err_inc;

   // Only the low byte carries frame content.
   assign rx_byte = i_rx_data[7:0];
   assign expired = (to_cnt == TO_BIT'(TIMEOUT - 1));
   assign chk_ok  = (rx_byte == (addr_r ^ dhi_r ^ dlo_r));

   always_comb begin
      state_d  = state_q;
      lat_addr = 1'b0;
      lat_dhi  = 1'b0;
      lat_dlo  = 1'b0;
      do_wr    = 1'b0;
      do_resp  = 1'b0;
      err_inc  = 1'b0;
      // A byte on the expiry cycle wins over the timeout in every data state.
      case (state_q)
         IDLE: if (i_rx_done_tick && rx_byte == HDR) state_d = ADDR;
         ADDR: begin
            if (i_rx_done_tick) begin
               lat_addr = 1'b1;
               state_d  = DHI;
            end else if (expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end
         end
         DHI: begin
            if (i_rx_done_tick) begin
               lat_dhi = 1'b1;
               state_d = DLO;
            end else if (expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end
         end
         DLO: begin
            if (i_rx_done_tick) begin
               lat_dlo = 1'b1;
               state_d = CHK;
            end else if (expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end
         end
         CHK: begin
            if (i_rx_done_tick) begin
               do_resp = 1'b1;
               do_wr   = chk_ok;
               err_inc = !chk_ok;
               state_d = WAIT_TX;
            end else if (expired) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_TX: if (i_tx_done_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         to_cnt     <= '0;
         addr_r     <= '0;
         dhi_r      <= '0;
         dlo_r      <= '0;
         o_tx_start <= 1'b0;
         o_tx_data  <= '0;
         o_wr_en    <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         o_err_cnt  <= '0;
         o_busy     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (i_rx_done_tick || expired || state_q == IDLE || state_q == WAIT_TX)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;
         if (lat_addr) addr_r <= rx_byte;
         if (lat_dhi)  dhi_r  <= rx_byte;
         if (lat_dlo)  dlo_r  <= rx_byte;
         o_wr_en    <= do_wr;
         if (do_wr) begin
            o_wr_addr <= addr_r;
            o_wr_data <= {dhi_r, dlo_r};
         end
         o_tx_start <= do_resp;
         if (do_resp) o_tx_data <= DATA_BITS'(chk_ok ? ACK : NAK);
         if (err_inc && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
         // Registered copy of "next state is not IDLE" so o_busy tracks state_q.
         o_busy <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser. Expected writes and responses are
// queued when a frame is sent and popped by a negedge monitor whenever the
// DUT strobes o_wr_en / o_tx_start.
module tb_uart_cmd_parser;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_rx_done_tick;
   logic [7:0] i_rx_data;
   logic       i_tx_done_tick;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_wr_en;
   logic [7:0] o_wr_addr;
   logic [15:0] o_wr_data;
   logic [7:0] o_err_cnt;
   logic       o_busy;

   int errors = 0;
   int checks = 0;
   int exp_err = 0;
   logic [23:0] wr_q[$];
   logic [7:0]  rsp_q[$];

   uart_cmd_parser #(.DATA_BITS(8), .TIMEOUT(T), .TO_BIT(8)) dut (
      .clk(clk), .rst(rst),
      .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
      .i_tx_done_tick(i_tx_done_tick),
      .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_err_cnt(o_err_cnt), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (o_wr_en) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) chk("wr_addr_data", {8'h0, o_wr_addr, o_wr_data}, {8'h0, wr_q.pop_front()});
         end
         if (o_tx_start) begin
            chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) chk("rsp_byte", 32'(o_tx_data), 32'(rsp_q.pop_front()));
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      i_rx_data = b;
      i_rx_done_tick = 1'b1;
      @(negedge clk);
      i_rx_done_tick = 1'b0;
   endtask

   task automatic tx_done();
      @(negedge clk);
      i_tx_done_tick = 1'b1;
      @(negedge clk);
      i_tx_done_tick = 1'b0;
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] c);
      logic ok;
      ok = ((a ^ dh ^ dl) == c);
      if (ok) wr_q.push_back({a, dh, dl});
      else if (exp_err < 255) exp_err++;
      rsp_q.push_back(ok ? 8'h06 : 8'h15);
      send(8'hA5); send(a); send(dh); send(dl); send(c);
      // Checksum tick was the last posedge: response must be visible now.
      chk("tx_start_lat", 32'(o_tx_start), 32'd1);
      chk("wr_en_lat", 32'(o_wr_en), 32'(ok));
      chk("busy_wait_tx", 32'(o_busy), 32'd1);
      @(negedge clk);
      chk("tx_start_1cyc", 32'(o_tx_start), 32'd0);
      chk("wr_en_1cyc", 32'(o_wr_en), 32'd0);
      tx_done();
      chk("busy_after_tx", 32'(o_busy), 32'd0);
      chk("err_cnt", 32'(o_err_cnt), 32'(exp_err));
   endtask

   task automatic chk_reset_vals();
      chk("rst_tx_start", 32'(o_tx_start), 32'd0);
      chk("rst_tx_data", 32'(o_tx_data), 32'd0);
      chk("rst_wr_en", 32'(o_wr_en), 32'd0);
      chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(o_wr_data), 32'd0);
      chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; i_rx_done_tick = 1'b0; i_rx_data = 8'h00; i_tx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;

      // Garbage in IDLE is discarded without counting, then a good frame.
      send(8'h00); send(8'hFF); send(8'h5A);
      chk("idle_garbage_busy", 32'(o_busy), 32'd0);
      chk("idle_garbage_err", 32'(o_err_cnt), 32'd0);
      frame(8'h01, 8'h00, 8'hFF, 8'hFE);

      // Good frame, then bad checksum (write registers must hold).
      frame(8'h12, 8'h34, 8'h56, 8'h70);
      frame(8'h12, 8'h34, 8'h56, 8'h71);
      chk("hold_addr", 32'(o_wr_addr), 32'h12);
      chk("hold_data", 32'(o_wr_data), 32'h3456);

      // Header byte used as data payload.
      frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);

      // Bytes in WAIT_TX are discarded: A5 there must not start a frame.
      wr_q.push_back(24'h010203);
      rsp_q.push_back(8'h06);
      send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h00);
      send(8'hA5);
      tx_done();
      chk("wait_tx_discard_busy", 32'(o_busy), 32'd0);

      // Timeout: A5 12 then silence -> back to IDLE, one error.
      send(8'hA5); send(8'h12);
      repeat (T - 1) @(negedge clk);
      chk("pre_expiry_busy", 32'(o_busy), 32'd1);
      @(negedge clk);
      exp_err++;
      chk("timeout_busy", 32'(o_busy), 32'd0);
      chk("timeout_err", 32'(o_err_cnt), 32'(exp_err));
      send(8'h34); send(8'h56); send(8'h70);
      chk("timeout_tail_busy", 32'(o_busy), 32'd0);

      // Byte on the exact expiry cycle is accepted.
      wr_q.push_back(24'h123456);
      rsp_q.push_back(8'h06);
      send(8'hA5); send(8'h12);
      repeat (T - 2) @(negedge clk);
      send(8'h34); send(8'h56); send(8'h70);
      chk("expiry_accept_start", 32'(o_tx_start), 32'd1);
      tx_done();
      chk("expiry_accept_err", 32'(o_err_cnt), 32'(exp_err));

      // Reset mid-frame aborts; remaining bytes and a stray tx_done are ignored.
      send(8'hA5); send(8'h12); send(8'h34);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_err = 0;
      chk_reset_vals();
      send(8'h56); send(8'h70);
      tx_done();
      chk("post_rst_busy", 32'(o_busy), 32'd0);
      chk("post_rst_addr", 32'(o_wr_addr), 32'd0);
      frame(8'h12, 8'h34, 8'h56, 8'h70);

      // Saturation.
      for (int i = 0; i < 256; i++) frame(8'(i), 8'h00, 8'h00, 8'(i) ^ 8'h01);
      chk("err_saturated", 32'(o_err_cnt), 32'hFF);

      repeat (3) @(negedge clk);
      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: UART byte width.
REQ-002 SHALL have parameter TIMEOUT, default 10_000: max idle clk cycles between bytes of one frame.
REQ-003 SHALL have parameter TO_BIT, default 14: timeout counter width.
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_rx_done_tick  input  1  one-cycle strobe from the UART receiver; i_rx_data valid.
REQ-007 SHALL have port i_rx_data  input  DATA_BITS  received byte.
REQ-008 SHALL have port i_tx_done_tick  input  1  one-cycle strobe from the UART transmitter, response byte sent.
REQ-009 SHALL have port o_tx_start  output  1  one-cycle request to the UART transmitter.
REQ-010 SHALL have port o_tx_data  output  DATA_BITS  response byte, held from o_tx_start until i_tx_done_tick.
REQ-011 SHALL have port o_wr_en  output  1  one-cycle register-write strobe.
REQ-012 SHALL have port o_wr_addr  output  8  write address, held until the next write.
REQ-013 SHALL have port o_wr_data  output  16  write data, held until the next write.
REQ-014 SHALL have port o_err_cnt  output  8  saturating count of rejected frames.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL parse 5-byte frames: 0xA5 header, ADDR, DHI, DLO, CHK.
REQ-017 CHK SHALL equal ADDR XOR DHI XOR DLO.
REQ-018 SHALL use states IDLE, ADDR, DHI, DLO, CHK, WAIT_TX.
REQ-019 IDLE: a 0xA5 byte -> ADDR; any other byte is discarded and leaves o_err_cnt unchanged.
REQ-020 ADDR/DHI/DLO: each byte is latched into its field register and advances the state; 0xA5 in these positions is treated as data.
REQ-021 CHK: byte arrives at cycle N -> checksum compared at cycle N -> state WAIT_TX at N+1.
REQ-022 Checksum match: at N+1, o_wr_en=1 for exactly one cycle, o_wr_addr/o_wr_data updated, o_tx_data=0x06, o_tx_start=1 for one cycle.
REQ-023 Checksum mismatch: at N+1, o_wr_en stays 0, o_wr_addr/o_wr_data unchanged, o_tx_data=0x15, o_tx_start=1 for one cycle, o_err_cnt+1.
REQ-024 WAIT_TX: on i_tx_done_tick -> IDLE; i_rx_done_tick bytes in WAIT_TX are discarded.
REQ-025 Timeout counter: cleared on every i_rx_done_tick and in IDLE/WAIT_TX; increments each cycle in ADDR..CHK.
REQ-026 Counter reaching TIMEOUT-1 with no byte: -> IDLE next cycle, o_err_cnt+1, no write, no response.
REQ-027 i_rx_done_tick in the same cycle as expiry: the byte is accepted and the timeout ignored.
REQ-028 o_err_cnt SHALL saturate at 0xFF; no wrap.
REQ-029 Frame complete with o_err_cnt increment: a single increment per event.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst high at a clock edge: state=IDLE, timeout counter=0, o_tx_start=0, o_tx_data=0x00, o_wr_en=0, o_wr_addr=0x00, o_wr_data=0x0000, o_err_cnt=0x00, o_busy=0.
REQ-032 rst mid-frame or in WAIT_TX SHALL abort with no write and no response; a later i_tx_done_tick in IDLE is ignored.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Bytes A5 12 34 56 70 -> one-cycle o_wr_en, addr 0x12, data 0x3456; o_tx_start with 0x06 at checksum tick+1; i_tx_done_tick -> o_busy=0.
REQ-035 Bytes A5 12 34 56 71 -> no o_wr_en; response 0x15; o_err_cnt=1.
REQ-036 Bytes 00 FF 5A, then a valid frame A5 01 00 FF FE -> only the last frame writes (addr 0x01, data 0x00FF); o_err_cnt=0.
REQ-037 Bytes A5 12, then TIMEOUT cycles silent -> IDLE, o_err_cnt=1; next valid frame accepted; also cover a byte arriving exactly on the expiry cycle, which must be accepted.
REQ-038 rst pulsed after A5 12 34 -> all outputs at reset values; remaining bytes 56 70 discarded; full frame afterwards writes normally.
REQ-039 256 bad-checksum frames -> o_err_cnt holds at 0xFF.
